// File: rtl/hilo_unit.sv
// HI/LO execution unit: drives an external pipelined multiplier, runs a 32-step
// restoring divider, and owns the architectural HI/LO registers.
module hilo_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero,
  output logic        mul_enable,
  output logic        mul_is_unsign,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result,
  input  logic        mul_done
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DFIX} state_e;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic        mul_is_unsign_q, mul_is_unsign_d;
  logic        dbz_q, dbz_d;
  logic [31:0] rem_q, rem_d;          // partial remainder (bit 32 lives only in the trial)
  logic [31:0] quo_q, quo_d;          // dividend shifts out as quotient shifts in
  logic [31:0] divisor_q, divisor_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

  logic        is_mdu_op;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] trial;

  assign is_mdu_op = (op == OP_MULT) || (op == OP_MULTU) ||
                     (op == OP_DIV)  || (op == OP_DIVU);

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a signal unassigned, which would infer a latch.
    state_d         = state_q;
    hi_d            = hi_q;
    lo_d            = lo_q;
    mul_a_d         = mul_a_q;
    mul_b_d         = mul_b_q;
    mul_is_unsign_d = mul_is_unsign_q;
    dbz_d           = dbz_q;
    rem_d           = rem_q;
    quo_d           = quo_q;
    divisor_d       = divisor_q;
    cnt_d           = cnt_q;
    neg_quo_d       = neg_quo_q;
    neg_rem_d       = neg_rem_q;

    a_neg = (op == OP_DIV) && src_a[31];
    b_neg = (op == OP_DIV) && src_b[31];
    a_mag = a_neg ? (~src_a + 32'd1) : src_a;
    b_mag = b_neg ? (~src_b + 32'd1) : src_b;
    trial = {rem_q, quo_q[31]} - {1'b0, divisor_q};

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_valid) begin
            case (op)
              OP_MTHI: begin
                hi_d  = src_a;
                dbz_d = 1'b0;
              end
              OP_MTLO: begin
                lo_d  = src_a;
                dbz_d = 1'b0;
              end
              OP_MULT, OP_MULTU: begin
                mul_a_d         = src_a;
                mul_b_d         = src_b;
                mul_is_unsign_d = (op == OP_MULTU);
                dbz_d           = 1'b0;
                state_d         = S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                if (src_b == 32'd0) begin
                  // Forced result flows through the normal DFIX write unnegated.
                  rem_d     = src_a;
                  quo_d     = 32'hFFFF_FFFF;
                  neg_quo_d = 1'b0;
                  neg_rem_d = 1'b0;
                  dbz_d     = 1'b1;
                  state_d   = S_DFIX;
                end else begin
                  rem_d     = 32'd0;
                  quo_d     = a_mag;
                  divisor_d = b_mag;
                  neg_quo_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  cnt_d     = 5'd0;
                  dbz_d     = 1'b0;
                  state_d   = S_DIV;
                end
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (mul_done) begin
            {hi_d, lo_d} = mul_result;
            state_d      = S_IDLE;
          end
        end
        S_DIV: begin
          if (!trial[32]) begin
            rem_d = trial[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = {rem_q[30:0], quo_q[31]};
            quo_d = {quo_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_DFIX;
        end
        S_DFIX: begin
          lo_d    = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
          hi_d    = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      hi_q            <= '0;
      lo_q            <= '0;
      mul_a_q         <= '0;
      mul_b_q         <= '0;
      mul_is_unsign_q <= 1'b0;
      dbz_q           <= 1'b0;
      rem_q           <= '0;
      quo_q           <= '0;
      divisor_q       <= '0;
      cnt_q           <= '0;
      neg_quo_q       <= 1'b0;
      neg_rem_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      hi_q            <= hi_d;
      lo_q            <= lo_d;
      mul_a_q         <= mul_a_d;
      mul_b_q         <= mul_b_d;
      mul_is_unsign_q <= mul_is_unsign_d;
      dbz_q           <= dbz_d;
      rem_q           <= rem_d;
      quo_q           <= quo_d;
      divisor_q       <= divisor_d;
      cnt_q           <= cnt_d;
      neg_quo_q       <= neg_quo_d;
      neg_rem_q       <= neg_rem_d;
    end
  end

  // Stall also covers the accept cycle so the issuing instruction is held.
  assign stall         = (state_q != S_IDLE) || (op_valid && is_mdu_op);
  assign mul_enable    = (state_q == S_MUL);
  assign hi            = hi_q;
  assign lo            = lo_q;
  assign div_by_zero   = dbz_q;
  assign mul_is_unsign = mul_is_unsign_q;
  assign mul_a         = mul_a_q;
  assign mul_b         = mul_b_q;

endmodule
